// File: rtl/led_step_shifter.sv
// led_step_shifter: LED pattern register stepped by rising edges of a slow,
// asynchronous STEP_IN level. STEP_IN is synchronized into MCLK and edge
// detected. The pattern rotates left, rotates right, bounces or holds.
module led_step_shifter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
  input  logic             MCLK,
  input  logic             RST_N,
  input  logic             STEP_IN,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic             DIR,
  output logic             STEP_PULSE
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  logic             s1, s2, s3;
  logic             tick;
  logic [WIDTH-1:0] q_nxt;
  logic             dir_nxt;
  mode_e            mode_sel;

  // The synchronizer resets high so that a STEP_IN that is already high
  // when reset is released does not produce a step.
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= STEP_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick     = s2 & ~s3;
  assign mode_sel = mode_e'(MODE);

  // Next pattern and direction. LOAD wins over a tick, and a tick only
  // moves the pattern when EN is set.
  always_comb begin
    q_nxt   = Q;
    dir_nxt = DIR;
    if (LOAD) begin
      q_nxt   = LOAD_VAL;
      dir_nxt = 1'b0;
    end else if (tick && EN) begin
      case (mode_sel)
        MODE_ROL: begin
          q_nxt   = {Q[WIDTH-2:0], Q[WIDTH-1]};
          dir_nxt = 1'b0;
        end
        MODE_ROR: begin
          q_nxt   = {Q[0], Q[WIDTH-1:1]};
          dir_nxt = 1'b1;
        end
        MODE_BOUNCE: begin
          // Only the end being approached is tested, so a pattern with
          // both end bits set still turns around at the correct wall.
          if (!DIR) begin
            if (Q[WIDTH-1]) begin
              dir_nxt = 1'b1;
              q_nxt   = Q >> 1;
            end else begin
              q_nxt   = Q << 1;
            end
          end else begin
            if (Q[0]) begin
              dir_nxt = 1'b0;
              q_nxt   = Q << 1;
            end else begin
              q_nxt   = Q >> 1;
            end
          end
        end
        default: begin
          q_nxt   = Q;
          dir_nxt = DIR;
        end
      endcase
    end
  end

  // Output registers. STEP_PULSE follows the tick regardless of EN, MODE
  // or LOAD.
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      Q          <= SEED;
      DIR        <= 1'b0;
      STEP_PULSE <= 1'b0;
    end else begin
      Q          <= q_nxt;
      DIR        <= dir_nxt;
      STEP_PULSE <= tick;
    end
  end

endmodule

// File: tb/tb_led_step_shifter.sv
// Testbench for led_step_shifter: directed sequences plus a randomized run,
// checked every cycle against a behavioural model of the pattern rules.
module tb_led_step_shifter;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         MCLK     = 1'b0;
  logic         RST_N    = 1'b0;
  logic         STEP_IN  = 1'b1;
  logic         EN       = 1'b1;
  logic [1:0]   MODE     = 2'd0;
  logic         LOAD     = 1'b0;
  logic [W-1:0] LOAD_VAL = '0;
  logic [W-1:0] Q;
  logic         DIR;
  logic         STEP_PULSE;

  int checks    = 0;
  int passes    = 0;
  int pulse_cnt = 0;
  bit cmp_en    = 0;

  // Model state: pattern, direction, pulse, last three STEP_IN samples
  int m_q     = 1;
  bit m_dir   = 0;
  bit m_pulse = 0;
  bit hist[$] = '{1'b1, 1'b1, 1'b1};

  int bq[16] = '{'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h40,
                 'h20, 'h10, 'h08, 'h04, 'h02, 'h01, 'h02, 'h04};
  bit bd[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  led_step_shifter #(.WIDTH(W), .SEED(8'h01)) dut (
    .MCLK       (MCLK),
    .RST_N      (RST_N),
    .STEP_IN    (STEP_IN),
    .EN         (EN),
    .MODE       (MODE),
    .LOAD       (LOAD),
    .LOAD_VAL   (LOAD_VAL),
    .Q          (Q),
    .DIR        (DIR),
    .STEP_PULSE (STEP_PULSE)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // A rising edge sampled at edge k acts at edge k+2: the step happens at
  // edge n when the sample at n-2 is 1 and the sample at n-3 is 0.
  task automatic model_edge();
    bit tick;
    tick = hist[1] && !hist[0];
    hist.push_back(STEP_IN);
    void'(hist.pop_front());
    m_pulse = tick;
    if (LOAD) begin
      m_q   = int'(LOAD_VAL);
      m_dir = 0;
    end else if (tick && EN) begin
      case (MODE)
        2'd0: begin m_q = ((m_q << 1) | (m_q >> (W - 1))) & MASK; m_dir = 0; end
        2'd1: begin m_q = ((m_q >> 1) | ((m_q & 1) << (W - 1))) & MASK; m_dir = 1; end
        2'd2: begin
          if (!m_dir) begin
            if (((m_q >> (W - 1)) & 1) == 1) begin m_dir = 1; m_q = m_q >> 1; end
            else m_q = (m_q << 1) & MASK;
          end else begin
            if ((m_q & 1) == 1) begin m_dir = 0; m_q = (m_q << 1) & MASK; end
            else m_q = m_q >> 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge MCLK or negedge RST_N);
    if (!RST_N) begin
      m_q = 1; m_dir = 0; m_pulse = 0; hist = '{1'b1, 1'b1, 1'b1};
    end else begin
      model_edge();
    end
  end

  // Per-cycle compare against the model, away from the active edge
  initial forever begin
    @(negedge MCLK);
    if (cmp_en) begin
      chk("cyc_q", int'(Q), m_q);
      chk("cyc_dir", int'(DIR), int'(m_dir));
      chk("cyc_pulse", int'(STEP_PULSE), int'(m_pulse));
    end
    if (STEP_PULSE === 1'b1) pulse_cnt++;
  end

  task automatic cyc(int n);
    repeat (n) begin @(negedge MCLK); #1; end
  endtask

  task automatic step(int lo, int hi);
    STEP_IN = 1'b0; cyc(lo);
    STEP_IN = 1'b1; cyc(hi);
  endtask

  task automatic do_load(int v);
    LOAD_VAL = W'(v); LOAD = 1'b1; cyc(1); LOAD = 1'b0;
  endtask

  initial begin
    int p0;
    int cnt;
    // Reset with STEP_IN high through release: no step, no pulse
    cyc(3);
    cmp_en = 1;
    RST_N  = 1'b1;
    cyc(12);
    chk("rst_q", int'(Q), 'h01);
    chk("rst_dir", int'(DIR), 0);
    chk("rst_no_pulse", pulse_cnt, 0);

    // Rotate left, with explicit latency check on the first step
    MODE = 2'd0; EN = 1'b1;
    p0 = pulse_cnt;
    STEP_IN = 1'b0; cyc(4);
    STEP_IN = 1'b1; cyc(2);
    chk("lat_q_early", int'(Q), 'h01);
    cyc(1);
    chk("lat_q", int'(Q), 'h02);
    chk("lat_pulse", int'(STEP_PULSE), 1);
    cyc(1);
    chk("lat_pulse_one", int'(STEP_PULSE), 0);
    for (int i = 2; i <= 9; i++) begin
      step(4, 4);
      chk("rol_q", int'(Q), (1 << (i % 8)));
    end
    chk("rol_pulses", pulse_cnt - p0, 9);

    // Bounce from 01
    do_load('h01);
    MODE = 2'd2;
    for (int i = 0; i < 16; i++) begin
      step(4, 4);
      chk("bnc_q", int'(Q), bq[i]);
      chk("bnc_dir", int'(DIR), int'(bd[i]));
    end

    // Rotate right from 81, then disabled steps
    do_load('h81);
    MODE = 2'd1;
    step(4, 4); chk("ror_q1", int'(Q), 'hC0);
    step(4, 4); chk("ror_q2", int'(Q), 'h60);
    step(4, 4); chk("ror_q3", int'(Q), 'h30);
    chk("ror_dir", int'(DIR), 1);
    EN = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) step(4, 4);
    chk("en0_q", int'(Q), 'h30);
    chk("en0_pulses", pulse_cnt - p0, 3);
    EN = 1'b1;

    // Zero pattern stays zero
    do_load(0);
    MODE = 2'd2; step(4, 4); chk("zero_bnc", int'(Q), 0);
    MODE = 2'd0; step(4, 4); chk("zero_rol", int'(Q), 0);

    // LOAD on the same edge as a tick wins
    MODE = 2'd0;
    LOAD_VAL = 8'hA5;
    STEP_IN = 1'b0; cyc(4);
    STEP_IN = 1'b1; cyc(2);
    LOAD = 1'b1; cyc(1); LOAD = 1'b0;
    chk("ldtick_q", int'(Q), 'hA5);
    chk("ldtick_dir", int'(DIR), 0);
    chk("ldtick_pulse", int'(STEP_PULSE), 1);
    cyc(2);

    // Reset mid-sequence with a tick in flight
    STEP_IN = 1'b0; cyc(4);
    STEP_IN = 1'b1; cyc(1);
    #2 RST_N = 1'b0;
    #1 chk("midrst_q", int'(Q), 'h01);
    chk("midrst_dir", int'(DIR), 0);
    cyc(1);
    p0 = pulse_cnt;
    RST_N = 1'b1;
    cyc(6);
    chk("midrst_cancel_q", int'(Q), 'h01);
    chk("midrst_cancel_pulse", pulse_cnt - p0, 0);

    // Randomized run
    cnt = 2;
    for (int c = 0; c < 2000; c++) begin
      cnt--;
      if (cnt == 0) begin
        STEP_IN = ~STEP_IN;
        cnt = int'($urandom_range(2, 5));
      end
      LOAD = ($urandom_range(0, 19) == 0);
      if (LOAD) LOAD_VAL = W'($urandom);
      if ($urandom_range(0, 15) == 0) MODE = 2'($urandom_range(0, 3));
      EN = ($urandom_range(0, 7) != 0);
      cyc(1);
    end
    LOAD = 1'b0;
    cyc(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
